ltc2600_spi_rx: RTL

- Synthesizable receiver/decoder for the LTC2600 serial write protocol.
- Oversamples `sck`, `sdi`, `csb` and `clrb` on the system clock and deframes 24–32-bit write sequences into command, address and data.
- Applies each command to a shadow model of the eight DAC input and DAC registers.
- Sits on the far end of the DAC SPI link: a loopback checker for the DAC write master and a readback source for firmware/debug.

---
 rtl/ltc2600_spi_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ltc2600_spi_rx.sv
// LTC2600 serial-write receiver: oversamples the SPI pins, deframes writes and
// keeps a shadow copy of the eight DAC input/DAC registers for readback.
module ltc2600_spi_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  csb,
    input  logic                  clrb,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic [3:0]            rx_command,
    output logic [3:0]            rx_address,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic [2:0]            rd_sel,
    output logic [DATA_WIDTH-1:0] rd_input,
    output logic [DATA_WIDTH-1:0] rd_dac,
    output logic [7:0]            dac_pd
);
    localparam int         SR_W    = 8 + DATA_WIDTH;
    localparam logic [5:0] MIN_CNT = 6'(SR_W);
    localparam logic [5:0] MAX_CNT = 6'(MAX_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state, state_nxt;
    logic [2:0]            sck_p, csb_p, clrb_p;
    logic [1:0]            sdi_p;
    logic                  sck_rise, csb_fall, csb_rise, clr_act;
    logic                  sr_clear, shift_en, done;
    logic                  armed, frame_ok, apply;
    logic [SR_W-1:0]       sr;
    logic [5:0]            cnt;
    logic [3:0]            f_cmd, f_addr;
    logic [DATA_WIDTH-1:0] f_data;
    logic [7:0]            ch_mask, pd_nxt;
    logic [DATA_WIDTH-1:0] in_reg [8];
    logic [DATA_WIDTH-1:0] dac_reg [8];
    logic [DATA_WIDTH-1:0] in_nxt [8];
    logic [DATA_WIDTH-1:0] dac_nxt [8];

    // Stage p0/p1: two-flop synchronizers; p2 is the edge-detect history.
    // csb syncs reset low so a frame already in progress at reset never arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_p  <= '0;
            sdi_p  <= '0;
            csb_p  <= '0;
            clrb_p <= '1;
        end else begin
            sck_p  <= {sck_p[1:0], sck};
            sdi_p  <= {sdi_p[0], sdi};
            csb_p  <= {csb_p[1:0], csb};
            clrb_p <= {clrb_p[1:0], clrb};
        end
    end

    assign sck_rise = sck_p[1] & ~sck_p[2];
    assign csb_fall = ~csb_p[1] & csb_p[2];
    assign csb_rise = csb_p[1] & ~csb_p[2];
    assign clr_act  = ~clrb_p[2];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csb_fall) state_nxt = SHIFT;
            SHIFT:   if (csb_rise) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sr_clear = (state != DONE) && csb_fall;
        shift_en = (state == SHIFT) && sck_rise && !csb_fall;
        done     = (state == DONE);
    end

    // Stage p3: deframe; only the trailing SR_W bits survive in the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else if (sr_clear) begin
            sr    <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else if (shift_en) begin
            sr <= {sr[SR_W-2:0], sdi_p[1]};
            if (cnt != 6'd63) cnt <= cnt + 6'd1;
        end
    end

    assign f_cmd    = sr[SR_W-1 -: 4];
    assign f_addr   = sr[SR_W-5 -: 4];
    assign f_data   = sr[DATA_WIDTH-1:0];
    assign frame_ok = (cnt >= MIN_CNT) && (cnt <= MAX_CNT);
    assign apply    = done && armed && frame_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            rx_command  <= '0;
            rx_address  <= '0;
            rx_data     <= '0;
        end else begin
            frame_valid <= apply;
            frame_error <= done && armed && !frame_ok;
            if (apply) begin
                rx_command <= f_cmd;
                rx_address <= f_addr;
                rx_data    <= f_data;
            end
        end
    end

    always_comb begin
        ch_mask = '0;
        if (f_addr == 4'hF)  ch_mask = '1;
        else if (!f_addr[3]) ch_mask[f_addr[2:0]] = 1'b1;
    end

    // Command 0010 chains: the updated input value feeds the all-channel DAC load.
    always_comb begin
        in_nxt  = in_reg;
        dac_nxt = dac_reg;
        pd_nxt  = dac_pd;
        if (apply && (ch_mask != 8'h00)) begin
            case (f_cmd)
                4'h0: for (int i = 0; i < 8; i++) if (ch_mask[i]) in_nxt[i] = f_data;
                4'h1: for (int i = 0; i < 8; i++) if (ch_mask[i]) begin
                    dac_nxt[i] = in_reg[i];
                    pd_nxt[i]  = 1'b0;
                end
                4'h2: begin
                    for (int i = 0; i < 8; i++) begin
                        if (ch_mask[i]) in_nxt[i] = f_data;
                        dac_nxt[i] = in_nxt[i];
                    end
                    pd_nxt = '0;
                end
                4'h3: for (int i = 0; i < 8; i++) if (ch_mask[i]) begin
                    in_nxt[i]  = f_data;
                    dac_nxt[i] = f_data;
                    pd_nxt[i]  = 1'b0;
                end
                4'h4: for (int i = 0; i < 8; i++) if (ch_mask[i]) pd_nxt[i] = 1'b1;
                default: ;
            endcase
        end
    end

    // Clear overrides any same-cycle command but leaves power-down flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                in_reg[i]  <= '0;
                dac_reg[i] <= '0;
            end
            dac_pd <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                in_reg[i]  <= clr_act ? '0 : in_nxt[i];
                dac_reg[i] <= clr_act ? '0 : dac_nxt[i];
            end
            dac_pd <= pd_nxt;
        end
    end

    assign rd_input = in_reg[rd_sel];
    assign rd_dac   = dac_reg[rd_sel];
endmodule
